// File: rtl/rv32i_mem_arbiter.sv
// rtl/rv32i_mem_arbiter.sv - I/D cache miss arbiter onto one burst memory port
// Define RV32I_ARB_RR_EN for round-robin arbitration instead of fixed data-over-instruction priority.
module rv32i_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-OFF_W){1'b1}}, {OFF_W{1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_I_RD = 3'd1;
  localparam logic [2:0] S_D_RD = 3'd2;
  localparam logic [2:0] S_D_WR = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]        state;
  logic [CNT_W-1:0]  beat;
  logic              gnt_d;
  logic [LINE_W-1:0] i_buf;
  logic [LINE_W-1:0] d_buf;
  logic              last_beat;
  logic              pick_d;
  logic [ADDR_W-1:0] sel_addr;

  assign last_beat = (beat == CNT_W'(BEATS - 1));

  // gnt_d doubles as the last-grant record: it only changes on a grant.
`ifdef RV32I_ARB_RR_EN
  assign pick_d = (d_read || d_write) && (!i_read || !gnt_d);
`else
  assign pick_d = d_read || d_write;
`endif

  assign sel_addr = pick_d ? d_addr : i_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      beat      <= '0;
      gnt_d     <= 1'b0;
      i_buf     <= '0;
      d_buf     <= '0;
      mem_addr  <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (d_read || d_write || i_read) begin
            gnt_d    <= pick_d;
            beat     <= '0;
            mem_addr <= sel_addr & LINE_MASK;
            if (pick_d && d_write) begin
              state     <= S_D_WR;
              mem_write <= 1'b1;
            end else begin
              state    <= pick_d ? S_D_RD : S_I_RD;
              mem_read <= 1'b1;
            end
          end
        end
        S_I_RD, S_D_RD: begin
          if (mem_resp) begin
            if (state == S_I_RD) i_buf[int'(beat)*BEAT_W +: BEAT_W] <= mem_rdata;
            else                 d_buf[int'(beat)*BEAT_W +: BEAT_W] <= mem_rdata;
            if (last_beat) begin
              beat     <= '0;
              mem_read <= 1'b0;
              state    <= S_DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_D_WR: begin
          if (mem_resp) begin
            if (last_beat) begin
              beat      <= '0;
              mem_write <= 1'b0;
              state     <= S_DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem_wdata = (state == S_D_WR) ? d_wdata[int'(beat)*BEAT_W +: BEAT_W] : '0;
  assign i_resp    = (state == S_DONE) && !gnt_d;
  assign d_resp    = (state == S_DONE) && gnt_d;
  assign i_rdata   = i_buf;
  assign d_rdata   = d_buf;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb/tb_rv32i_mem_arbiter.sv - directed self-checking bench for rv32i_mem_arbiter
module tb_rv32i_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [31:0]  i_addr;
  logic [255:0] i_rdata;
  logic         i_resp;
  logic         d_read;
  logic         d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic [255:0] d_rdata;
  logic         d_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] pat [4];
  int  k = 0;
  bit  wait_mode = 1'b0;
  bit  wchk = 1'b0;
  bit  stray = 1'b0;

  rv32i_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] line_of();
    return {pat[3], pat[2], pat[1], pat[0]};
  endfunction

  // Memory model: k counts beats acknowledged so far in the current burst.
  always @(negedge clk) begin
    if (d_read && d_write) begin
      n_bad++;
      $error("FAIL d_rd_wr_both: observed d_read=1 d_write=1 expected exclusive");
    end
    if (mem_resp) k++;
    if (mem_read || mem_write) begin
      if (wchk && mem_write) chk("wdata_hold", mem_wdata, d_wdata[(k & 3)*64 +: 64]);
      mem_resp  = wait_mode ? !mem_resp : 1'b1;
      mem_rdata = pat[k & 3];
    end else begin
      k = 0;
      mem_resp  = stray;
      mem_rdata = '0;
    end
  end

  task automatic run_until(input bit want_d, output int lat, output logic [31:0] addr,
                           output bit rd_seen, output bit wr_seen);
    bit done;
    lat = 1; addr = '0; rd_seen = 0; wr_seen = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_read || mem_write) addr = mem_addr;
      rd_seen |= mem_read;
      wr_seen |= mem_write;
      if (want_d ? d_resp : i_resp) done = 1;
    end
    chk("resp_timeout", {255'd0, done}, 256'd1);
  endtask

  task automatic set_pat(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    pat[0] = {8{b0}}; pat[1] = {8{b1}}; pat[2] = {8{b2}}; pat[3] = {8{b3}};
  endtask

  initial begin
    int lat;
    logic [31:0] addr;
    bit rd_seen, wr_seen, first_d;

    rst_n = 0; i_read = 0; i_addr = '0; d_read = 0; d_write = 0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_resp = 0;
    set_pat(8'h11, 8'h22, 8'h33, 8'h44);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp", {i_resp, d_resp}, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    rst_n = 1;
    @(posedge clk); #1;

    // Instruction fetch, zero-wait memory
    i_addr = 32'h0000_1234; i_read = 1;
    run_until(0, lat, addr, rd_seen, wr_seen);
    chk("if_latency", lat, 6);
    chk("if_mem_addr", addr, 32'h0000_1220);
    chk("if_kind", {rd_seen, wr_seen}, 2'b10);
    chk("if_rdata", i_rdata, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
    chk("if_no_d_resp", d_resp, 0);
    @(posedge clk); #1;
    i_read = 0;
    chk("if_pulse_width", i_resp, 0);

    // Writeback with a wait state between every beat
    wait_mode = 1; wchk = 1;
    d_addr  = 32'h8000_0040;
    d_wdata = {{16{4'hA}}, {16{4'hB}}, {16{4'hC}}, {16{4'hD}}};
    d_write = 1;
    run_until(1, lat, addr, rd_seen, wr_seen);
    chk("wb_latency", lat, 9);
    chk("wb_mem_addr", addr, 32'h8000_0040);
    chk("wb_kind", {rd_seen, wr_seen}, 2'b01);
    @(posedge clk); #1;
    d_write = 0; wchk = 0; wait_mode = 0;
    chk("wb_pulse_width", d_resp, 0);

    // Simultaneous reads; the last grant was data
`ifdef RV32I_ARB_RR_EN
    first_d = 0;
`else
    first_d = 1;
`endif
    set_pat(8'h55, 8'h66, 8'h77, 8'h88);
    i_addr = 32'h2000_0010; d_addr = 32'h3000_007F;
    i_read = 1; d_read = 1;
    run_until(first_d, lat, addr, rd_seen, wr_seen);
    chk("sim_first_addr", addr, first_d ? 32'h3000_0060 : 32'h2000_0000);
    chk("sim_first_other_resp", first_d ? i_resp : d_resp, 0);
    chk("sim_first_rdata", first_d ? d_rdata : i_rdata, line_of());
    @(posedge clk); #1;
    if (first_d) d_read = 0; else i_read = 0;
    run_until(!first_d, lat, addr, rd_seen, wr_seen);
    chk("sim_second_addr", addr, first_d ? 32'h2000_0000 : 32'h3000_0060);
    chk("sim_second_rdata", first_d ? i_rdata : d_rdata, line_of());
    @(posedge clk); #1;
    i_read = 0; d_read = 0;

    // Request dropped after the first beat; burst still completes
    set_pat(8'h99, 8'hAB, 8'hCD, 8'hEF);
    d_addr = 32'h0000_0040; d_read = 1;
    @(posedge clk); #1;
    chk("drop_granted", mem_read, 1);
    @(posedge clk); #1;
    d_read = 0;
    run_until(1, lat, addr, rd_seen, wr_seen);
    chk("drop_latency", lat, 4);
    chk("drop_rdata", d_rdata, line_of());
    @(posedge clk); #1;
    chk("drop_pulse_width", d_resp, 0);
    @(posedge clk); #1;
    chk("drop_idle", {mem_read, mem_write, i_resp, d_resp}, 0);

    // Request held through its resp cycle, then a stray mem_resp in IDLE
    d_addr = 32'h0000_0100; d_read = 1;
    run_until(1, lat, addr, rd_seen, wr_seen);
    @(posedge clk); #1;
    d_read = 0; stray = 1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("b2b_no_regrant", {mem_read, mem_write, i_resp, d_resp}, 0);
    end
    stray = 0;
    set_pat(8'h01, 8'h02, 8'h03, 8'h04);
    i_addr = 32'h0000_0200; i_read = 1;
    run_until(0, lat, addr, rd_seen, wr_seen);
    chk("stray_after_latency", lat, 6);
    chk("stray_after_rdata", i_rdata, line_of());
    @(posedge clk); #1;
    i_read = 0;

    // Reset during the second beat of a writeback
    d_addr = 32'h0000_0300; d_write = 1;
    @(posedge clk); #1;
    chk("rstmid_write_on", mem_write, 1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("rstmid_mem_write", mem_write, 0);
    chk("rstmid_mem_addr", mem_addr, 0);
    chk("rstmid_mem_wdata", mem_wdata, 0);
    chk("rstmid_rdata", {i_rdata, d_rdata} != 512'd0, 0);
    d_write = 0;
    #2 rst_n = 1;
    @(posedge clk); #1;
    chk("rstmid_no_resp", {d_resp, mem_write}, 0);
    set_pat(8'hC1, 8'hC2, 8'hC3, 8'hC4);
    i_addr = 32'h0000_0444; i_read = 1;
    run_until(0, lat, addr, rd_seen, wr_seen);
    chk("rstmid_if_latency", lat, 6);
    chk("rstmid_if_addr", addr, 32'h0000_0440);
    chk("rstmid_if_rdata", i_rdata, line_of());
    @(posedge clk); #1;
    i_read = 0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_mem_arbiter.md
Name: rv32i_mem_arbiter

Overview:
- Shares one burst-oriented physical memory port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined RV32I core.
- Serializes line writes into beats and assembles read beats into a line.
- Returns one response pulse to the requester that was granted.
- Sits between the two L1 caches and the physical memory controller.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 256, cache line width in bits.
- BEAT_W, 64, memory data beat width. LINE_W/BEAT_W = BEATS (default 4), a power of two ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  icache line read request, held until i_resp
- i_addr  in  ADDR_W  icache line address
- i_rdata  out  LINE_W  assembled line, valid while i_resp=1
- i_resp  out  1  one-cycle completion pulse to icache
- d_read  in  1  dcache line read request, held until d_resp
- d_write  in  1  dcache line writeback request, held until d_resp
- d_addr  in  ADDR_W  dcache line address
- d_wdata  in  LINE_W  writeback line, held stable with d_write
- d_rdata  out  LINE_W  assembled line, valid while d_resp=1
- d_resp  out  1  one-cycle completion pulse to dcache
- mem_addr  out  ADDR_W  line-aligned burst address (low log2(LINE_W/8) bits forced 0)
- mem_read  out  1  burst read request, held until the last beat
- mem_write  out  1  burst write request, held until the last beat
- mem_wdata  out  BEAT_W  current write beat, beat 0 = line bits [BEAT_W-1:0]
- mem_rdata  in  BEAT_W  read beat, valid when mem_resp=1
- mem_resp  in  1  per-beat acknowledge

Behaviour:
- Reset: asynchronous on rst_n low. State=IDLE, beat counter=0, grant/last-grant=instruction. All outputs are 0, including line buffers, mem_* and resp.
- States: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE: samples requests at the clock edge. If d_write, go to D_WR. Else if d_read, go to D_RD. Else if i_read, go to I_RD. Otherwise stay in IDLE. Fixed priority is data over instruction.
- mem_addr, mem_read and mem_write are registered. They assert the cycle after the grant edge and are captured from the requester's address at grant.
- d_read and d_write both high: write wins. This condition is illegal for the requester; the bench flags it.
- I_RD/D_RD: on each cycle with mem_resp=1, write mem_rdata into the line buffer slice [beat*BEAT_W +: BEAT_W] and increment the beat counter. After the beat with counter=BEATS-1, deassert mem_read, clear the counter and go to DONE.
- D_WR: mem_wdata = d_wdata slice selected by the beat counter. The counter advances on mem_resp. After the last beat, deassert mem_write and go to DONE.
- DONE: one cycle. Pulse i_resp or d_resp for the granted requester. Its rdata is valid (the buffer for a write) for that cycle. Then go to IDLE.
- The requester must drop its request in the cycle following resp. IDLE therefore never re-grants a completed request.
- Latency with a zero-wait memory: grant edge, then BEATS beat cycles, then one DONE cycle. A request seen at edge N gives resp in cycle N+BEATS+2.
- mem_resp outside I_RD/D_RD/D_WR is ignored.
- Request deasserted mid-burst: the burst still completes and the resp pulse is still issued. No abort.
- A new request arriving during a burst waits. It is evaluated only in IDLE.
- Reset mid-burst: immediate return to IDLE with all outputs 0. The partially assembled line is discarded.
- i_rdata and d_rdata hold their last value outside resp cycles. Only the resp level is contractual.

Optional Feature:
- RV32I_ARB_RR_EN defined: round-robin arbitration. When both sides request in IDLE, grant the side not granted last. The last-grant register updates on every grant. Write still beats read within the data side.
- Undefined: fixed data-over-instruction priority as above. The last-grant register is not implemented.

Test Plan:
- Reset mid-burst: assert rst_n=0 during the 2nd beat of a D_WR -> mem_write=0 immediately, no d_resp, next i_read served normally from IDLE.
- Instruction fetch: i_read, i_addr=0x0000_1234, memory returns beats 0x11..,0x22..,0x33..,0x44.. with zero wait -> mem_addr=0x0000_1220, 4 beats, i_resp one cycle with i_rdata={0x44..,0x33..,0x22..,0x11..}, latency 6 cycles.
- Writeback with wait states: d_write, d_addr=0x8000_0040, d_wdata=256'hA..D, mem_resp every other cycle -> mem_wdata presents slices 0..3 in order, each held until acked, d_resp once after the 4th ack.
- Simultaneous i_read and d_read in IDLE, macro undefined -> D_RD served first, then I_RD. With RV32I_ARB_RR_EN and last grant=data -> I_RD served first.
- Request dropped mid-burst: d_read deasserted after beat 1 -> remaining 3 beats still consumed, d_resp pulses once, state returns to IDLE.
- Back-to-back: d_read held continuously after its resp for exactly one extra cycle (requester drops the cycle after resp) -> no second grant. A stray mem_resp in IDLE causes no state change.
